key_tone_gen: RTL
=================

# key_tone_gen

Synthesizable, parametrised successor to the keyboard tone generator. It samples a vector of piano-key inputs, priority-encodes the pressed key into an 88-key piano number, and looks up a half-period from an elaboration-time table. It then produces a glitch-free square-wave tone by counting cycles of the single system clock; no `#delay` timing is used. The block adds octave shift, note-on/note-off event pulses and clean start/stop, and feeds the audio output stage.

## Interface
- `NUM_KEYS`, 12: number of key inputs; `keys[i]` maps to piano key `BASE_KEY+i`.
- `BASE_KEY`, 40: piano number of `keys[0]` (40 = C4).
- `CLK_HZ`, 50_000_000: frequency of `clock` in Hz.
- `CNT_W`, 20: width of the half-period counter and table entries.
- `KEY_W`, 7: width of `key_num`.

- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `keys`  in  NUM_KEYS  key-pressed levels, asynchronous to `clock`.
- `oct`  in  2  octave select: 0 nominal, 1 +1 octave, 2 +2 octaves, 3 −1 octave.
- `key_valid`  out  1  at least one key is held (registered).
- `key_num`  out  KEY_W  piano number of the selected key; holds its last value when `key_valid`=0.
- `note_on`  out  1  one-cycle pulse on the rising edge of `key_valid`.
- `note_off`  out  1  one-cycle pulse on the falling edge of `key_valid`.
- `tone`  out  1  square-wave output.
- `busy`  out  1  tone generator active, including the release tail.

## Operation
- **Table**
  - Built at elaboration: `f(k) = 440 * 2^((k-49)/12)`, `half(k) = round(CLK_HZ / (2*f(k)))`.
  - Real arithmetic appears only in constant functions; there is no real-valued logic in hardware.
  - Entries clamp to [2, 2^CNT_W−1].
- **Key sampling**
  - Stage 1 registers `keys` into `keys_q`.
  - Stage 2 priority-encodes `keys_q` with the lowest index winning, then registers `key_valid`, `key_num` and `half_sel`.
  - `half_sel` is the table entry shifted by `oct`: 1 → >>1, 2 → >>2, 3 → <<1 saturating to 2^CNT_W−1. The result is clamped to a minimum of 2.
- **States:** IDLE, RUN, TAIL.
  - IDLE: `tone`=0, counter held at 0. If `key_valid`=1, go to RUN, set `tone`=1 and load the counter with `half_sel−1`.
  - RUN, counter≠0: decrement.
  - RUN, counter=0: toggle `tone` and reload with the current `half_sel−1`. A key or `oct` change while running therefore takes effect at the next toggle, with no phase restart and no runt pulse.
  - RUN, `key_valid` falls: if `tone`=0, go to IDLE immediately. If `tone`=1, go to TAIL.
  - TAIL: keep counting. At counter=0, set `tone`=0 and go to IDLE.
  - TAIL, `key_valid` rises again before the count ends: return to RUN with no reload and no phase break. This is treated as a key change.
- `busy` = (state ≠ IDLE).
- `note_on` and `note_off` are edge detects of registered `key_valid` and never assert in the same cycle.
- **Reset**
  - All outputs = 0, state = IDLE, counter = 0, `keys_q` = 0.
  - Reset mid-note drops `tone` to 0 on that edge and emits no `note_off`.

## Timing
- `keys` change sampled at edge n → `key_valid`, `key_num` and `note_on`/`note_off` update at edge n+1.
- `tone` first rises at edge n+2.
- High and low phases last exactly `half_sel` cycles each; period = 2·`half_sel`.
- Steady-state jitter is 0 cycles.
- Release latency is at most the remainder of the current high phase.
- Throughput is one key event per cycle. Keys pulsing for a single cycle still produce a `note_on` and a `note_off` pair, plus one full high phase.

## Test plan
1. **Basic note.** CLK_HZ=1_000_000, `oct`=0. Hold `keys[9]` (key 49) → `key_num`=49, `note_on` 1 cycle, `tone` high 1136 and low 1136 cycles repeatedly, `busy`=1.
2. **Priority and key change.** Hold `keys[0]` and `keys[10]` → `key_num`=40, half=1911. Release `keys[0]` mid-phase → `key_num`=50, no `note_off`. The current phase completes at 1911; subsequent phases are 1073.
3. **Octave.** Key 49 with `oct`=1 → phases of 568. With `oct`=3 → 2272. With `oct`=2 → 284. Switching `oct` mid-phase changes only the next phase.
4. **Release tail.** Release while `tone`=1 with 500 cycles left → `note_off` at n+1, `tone` stays high until the phase ends, then 0, `busy` 0. Release while `tone`=0 → IDLE, `tone`=0 immediately.
5. **Re-press in tail.** Re-assert a key during TAIL → `note_on` pulses, `tone` continues with no break, and the next phase uses the new `half_sel`.
6. **Reset mid-note.** Assert `reset` while `tone`=1 → all outputs 0 on that edge, no `note_off`. After release with a key still held, the sequence restarts exactly as in scenario 1.

Source files
------------

// File: rtl/key_tone_gen.sv
// key_tone_gen: samples piano-key levels, priority-encodes the lowest pressed
// key, looks up its half-period from an elaboration-time table and produces a
// square-wave tone by counting system clock cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no tone, counter parked at 0, waiting for a held key
// RUN   | key held, tone toggles every half_sel cycles
// TAIL  | key released during a high phase, finishing that phase
module key_tone_gen #(
  parameter int NUM_KEYS = 12,
  parameter int BASE_KEY = 40,
  parameter int CLK_HZ   = 50_000_000,
  parameter int CNT_W    = 20,
  parameter int KEY_W    = 7
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  input  logic [1:0]          oct_i,
  output logic                key_valid_o,
  output logic [KEY_W-1:0]    key_num_o,
  output logic                note_on_o,
  output logic                note_off_o,
  output logic                tone_o,
  output logic                busy_o
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CNT_W-1:0] HALF_MAX = '1;
  localparam logic [CNT_W-1:0] HALF_MIN = CNT_W'(2);

  // Equal-tempered half-periods in clock cycles, one CNT_W field per key.
  // Real arithmetic lives only here and is folded away at elaboration.
  function automatic logic [NUM_KEYS*CNT_W-1:0] build_half_tbl();
    logic [NUM_KEYS*CNT_W-1:0] tbl;
    real freq;
    real half;
    real max_v;
    tbl   = '0;
    max_v = (2.0 ** CNT_W) - 1.0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      freq = 440.0 * (2.0 ** ($itor(BASE_KEY + i - 49) / 12.0));
      half = ($itor(CLK_HZ) / (2.0 * freq)) + 0.5;
      if (half > max_v) half = max_v;
      if (half < 2.0) half = 2.0;
      tbl[i*CNT_W +: CNT_W] = CNT_W'($rtoi(half));
    end
    return tbl;
  endfunction

  localparam logic [NUM_KEYS*CNT_W-1:0] HALF_TBL = build_half_tbl();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  logic [NUM_KEYS-1:0] keys_q;
  logic                any_d;
  logic [IDX_W-1:0]    sel_d;
  logic [CNT_W-1:0]    tbl_entry;
  logic [CNT_W-1:0]    shifted;
  logic [CNT_W-1:0]    half_sel_d;

  logic                key_valid_q;
  logic [KEY_W-1:0]    key_num_q;
  logic [CNT_W-1:0]    half_sel_q;
  logic                note_on_q;
  logic                note_off_q;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tone_q, tone_d;
  logic [CNT_W-1:0]    reload;
  logic                cnt_zero;

  // Stage 1: bring the asynchronous key levels into the clock domain.
  always_ff @(posedge clock_i) begin
    if (reset_i) keys_q <= '0;
    else         keys_q <= keys_i;
  end

  // Priority encoder: scanning downwards lets the lowest pressed key win.
  always_comb begin
    any_d = 1'b0;
    sel_d = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_q[i]) begin
        any_d = 1'b1;
        sel_d = IDX_W'(i);
      end
    end
  end

  // Octave shift of the table entry; the upward shift saturates rather than wraps.
  always_comb begin
    tbl_entry = HALF_TBL[int'(sel_d)*CNT_W +: CNT_W];
    case (oct_i)
      2'd1:    shifted = tbl_entry >> 1;
      2'd2:    shifted = tbl_entry >> 2;
      2'd3:    shifted = tbl_entry[CNT_W-1] ? HALF_MAX : (tbl_entry << 1);
      default: shifted = tbl_entry;
    endcase
    half_sel_d = (shifted < HALF_MIN) ? HALF_MIN : shifted;
  end

  // Stage 2: registered key state and note edge pulses; key_num/half_sel hold on release.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      key_valid_q <= 1'b0;
      key_num_q   <= '0;
      half_sel_q  <= HALF_MIN;
      note_on_q   <= 1'b0;
      note_off_q  <= 1'b0;
    end else begin
      key_valid_q <= any_d;
      note_on_q   <= any_d & ~key_valid_q;
      note_off_q  <= ~any_d & key_valid_q;
      if (any_d) begin
        key_num_q  <= KEY_W'(BASE_KEY) + KEY_W'(sel_d);
        half_sel_q <= half_sel_d;
      end
    end
  end

  // Tone FSM state, half-period down-counter and tone register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
    end
  end

  // Next state: reload only at terminal count, so pitch changes land on a phase boundary.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tone_d   = tone_q;
    reload   = half_sel_q - CNT_W'(1);
    cnt_zero = (cnt_q == '0);
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        cnt_d  = '0;
        if (key_valid_q) begin
          state_d = S_RUN;
          tone_d  = 1'b1;
          cnt_d   = reload;
        end
      end
      S_RUN: begin
        if (!key_valid_q) begin
          if (!tone_q || cnt_zero) begin
            state_d = S_IDLE;
            tone_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = S_TAIL;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end else if (cnt_zero) begin
          tone_d = ~tone_q;
          cnt_d  = reload;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TAIL: begin
        if (key_valid_q) begin
          // Re-press: resume running on the same phase without restarting it.
          state_d = S_RUN;
          if (cnt_zero) begin
            tone_d = ~tone_q;
            cnt_d  = reload;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (cnt_zero) begin
          state_d = S_IDLE;
          tone_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_valid_o = key_valid_q;
  assign key_num_o   = key_num_q;
  assign note_on_o   = note_on_q;
  assign note_off_o  = note_off_q;
  assign tone_o      = tone_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
